// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and instruction memory.
// The master drives the request; the slave returns the word in the same cycle as ready.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, requests instructions over the imem handshake and fills the
// IF/ID register. It handles decode backpressure and branch/jump redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned GAP      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_address_i,
  pc_fetch_unit_if.master        imem,
  output logic                   inst_valid_o,
  output logic [31:0]            inst_word_o,
  output logic [31:0]            inst_address_o
);

  typedef enum logic [1:0] {StBoot, StFetch, StStall, StFlush} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        inst_valid_q;
  logic [31:0] inst_word_q;
  logic [31:0] inst_address_q;

  logic [31:0] pc_next_seq;
  logic [31:0] redirect_pc;
  logic        held_and_stalled;

  // Wraps modulo 2^32 by construction.
  assign pc_next_seq      = pc_q + 32'(GAP);
  // Redirect targets are forced to word alignment.
  assign redirect_pc      = redirect_address_i & ~32'h0000_0003;
  assign held_and_stalled = inst_valid_q && stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StBoot;
      pc_q           <= RESET_PC;
      inst_valid_q   <= 1'b0;
      inst_word_q    <= 32'h0;
      inst_address_q <= 32'h0;
    end else if (redirect_valid_i) begin
      // Redirect beats stall and any same-cycle memory response.
      state_q      <= StFlush;
      pc_q         <= redirect_pc;
      inst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StBoot: state_q <= StFetch;
        StFetch: begin
          if (held_and_stalled) begin
            state_q <= StStall;
          end else if (imem.imem_ready) begin
            inst_word_q    <= imem.imem_rdata;
            inst_address_q <= pc_q;
            inst_valid_q   <= 1'b1;
            pc_q           <= pc_next_seq;
          end else if (inst_valid_q) begin
            inst_valid_q <= 1'b0;
          end
        end
        StStall: begin
          if (!stall_i) begin
            inst_valid_q <= 1'b0;
            state_q      <= StFetch;
          end
        end
        StFlush: state_q <= StFetch;
        default: state_q <= StBoot;
      endcase
    end
  end

  always_comb begin
    imem.imem_req  = (state_q == StFetch) && !held_and_stalled;
    imem.imem_addr = pc_q;
  end

  assign inst_valid_o   = inst_valid_q;
  assign inst_word_o    = inst_word_q;
  assign inst_address_o = inst_address_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: per-cycle vector table plus an instruction scoreboard, a second
// instance with a high reset PC for wraparound, and an asynchronous reset mid-request.
module tb_pc_fetch_unit;

  localparam logic [31:0] Key    = 32'hC0DE_0000;
  localparam logic [31:0] HiBase = 32'hFFFF_FFF8;
  localparam int          NumVec = 23;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        rv    = 1'b0;
  logic [31:0] raddr = 32'h0;
  logic        ready = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();
  pc_fetch_unit_if bus_hi ();

  assign bus.imem_ready    = ready;
  assign bus.imem_rdata    = bus.imem_addr ^ Key;
  assign bus_hi.imem_ready = ready;
  assign bus_hi.imem_rdata = bus_hi.imem_addr ^ Key;

  logic        iv, iv_hi;
  logic [31:0] iw, ia, iw_hi, ia_hi;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .GAP(4)) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall_i            (stall),
    .redirect_valid_i   (rv),
    .redirect_address_i (raddr),
    .imem               (bus),
    .inst_valid_o       (iv),
    .inst_word_o        (iw),
    .inst_address_o     (ia)
  );

  pc_fetch_unit #(.RESET_PC(HiBase), .GAP(4)) u_dut_hi (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall_i            (stall),
    .redirect_valid_i   (rv),
    .redirect_address_i (raddr),
    .imem               (bus_hi),
    .inst_valid_o       (iv_hi),
    .inst_word_o        (iw_hi),
    .inst_address_o     (ia_hi)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] raddr;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] iaddr;
  } vec_t;

  vec_t        vecs[NumVec];
  logic [31:0] sb_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] ra,
                              input logic rdy, input logic rq, input logic [31:0] ad,
                              input logic v, input logic [31:0] ia_e);
    vec_t t;
    t.stall = s;  t.rv   = r;  t.raddr = ra; t.ready = rdy;
    t.req   = rq; t.addr = ad; t.valid = v;  t.iaddr = ia_e;
    return t;
  endfunction

  initial begin
    //               stall rv raddr         rdy req addr          vld iaddr
    vecs[0]  = mk(0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0);   // boot
    vecs[1]  = mk(0, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0);
    vecs[3]  = mk(1, 0, 32'h0,   1, 0, 32'h8,   1, 32'h4);   // stall x4
    vecs[4]  = mk(1, 0, 32'h0,   1, 0, 32'h8,   1, 32'h4);
    vecs[5]  = mk(1, 0, 32'h0,   1, 0, 32'h8,   1, 32'h4);
    vecs[6]  = mk(1, 0, 32'h0,   1, 0, 32'h8,   1, 32'h4);
    vecs[7]  = mk(0, 0, 32'h0,   0, 0, 32'h8,   1, 32'h4);   // release, consumed
    vecs[8]  = mk(0, 0, 32'h0,   0, 1, 32'h8,   0, 32'h0);   // ready low x3
    vecs[9]  = mk(0, 0, 32'h0,   0, 1, 32'h8,   0, 32'h0);
    vecs[10] = mk(0, 0, 32'h0,   0, 1, 32'h8,   0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,   1, 1, 32'h8,   0, 32'h0);
    vecs[12] = mk(0, 0, 32'h0,   0, 1, 32'hC,   1, 32'h8);   // drop once consumed
    vecs[13] = mk(0, 0, 32'h0,   0, 1, 32'hC,   0, 32'h0);
    vecs[14] = mk(0, 0, 32'h0,   1, 1, 32'hC,   0, 32'h0);
    vecs[15] = mk(0, 0, 32'h0,   1, 1, 32'h10,  1, 32'hC);
    vecs[16] = mk(0, 1, 32'h103, 1, 1, 32'h14,  1, 32'h10);  // redirect vs ready
    vecs[17] = mk(0, 0, 32'h0,   1, 0, 32'h100, 0, 32'h0);   // flush
    vecs[18] = mk(0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0);
    vecs[19] = mk(1, 1, 32'h200, 1, 0, 32'h104, 1, 32'h100); // redirect vs stall
    vecs[20] = mk(1, 0, 32'h0,   1, 0, 32'h200, 0, 32'h0);
    vecs[21] = mk(0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h0);
    vecs[22] = mk(0, 0, 32'h0,   0, 1, 32'h204, 1, 32'h200);

    #1 rst_n = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, iv}, 32'h0);
    chk("rst_word", iw, 32'h0);
    chk("rst_iaddr", ia, 32'h0);
    chk("rst_hi_addr", bus_hi.imem_addr, HiBase);

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      stall = vecs[i].stall;
      rv    = vecs[i].rv;
      raddr = vecs[i].raddr;
      ready = vecs[i].ready;
      #2;
      chk($sformatf("c%0d_req", i), {31'b0, bus.imem_req}, {31'b0, vecs[i].req});
      if (vecs[i].req) chk($sformatf("c%0d_addr", i), bus.imem_addr, vecs[i].addr);
      chk($sformatf("c%0d_valid", i), {31'b0, iv}, {31'b0, vecs[i].valid});
      if (vecs[i].valid) chk($sformatf("c%0d_iaddr", i), ia, vecs[i].iaddr);
      // Same stimulus before the first redirect: the high-PC copy runs 8 bytes behind, mod 2^32.
      if (i <= 16) begin
        chk($sformatf("c%0d_hi_req", i), {31'b0, bus_hi.imem_req}, {31'b0, vecs[i].req});
        if (vecs[i].req)
          chk($sformatf("c%0d_hi_addr", i), bus_hi.imem_addr, vecs[i].addr + HiBase);
        if (vecs[i].valid) begin
          chk($sformatf("c%0d_hi_iaddr", i), ia_hi, vecs[i].iaddr + HiBase);
          chk($sformatf("c%0d_hi_word", i), iw_hi, (vecs[i].iaddr + HiBase) ^ Key);
        end
      end
      // Scoreboard: pop on consumption, discard on redirect, push on accepted fetch.
      if (iv && !stall) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("c%0d_sb_underflow", i), ia, 32'hDEAD_BEEF);
        end else begin
          logic [31:0] exp_a;
          exp_a = sb_q.pop_front();
          chk($sformatf("c%0d_sb_iaddr", i), ia, exp_a);
          chk($sformatf("c%0d_sb_word", i), iw, exp_a ^ Key);
        end
      end
      if (vecs[i].rv) sb_q.delete();
      if (vecs[i].req && vecs[i].ready && !vecs[i].rv) sb_q.push_back(vecs[i].addr);
    end

    // Asynchronous reset while a request is outstanding and an instruction is held.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_valid", {31'b0, iv}, 32'h0);
    chk("arst_word", iw, 32'h0);
    chk("arst_iaddr", ia, 32'h0);
    chk("arst_hi_addr", bus_hi.imem_addr, HiBase);
    sb_q.delete();

    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    rv    = 1'b0;
    ready = 1'b1;
    #2;
    chk("rel_boot_req", {31'b0, bus.imem_req}, 32'h0);
    @(negedge clk);
    #2;
    chk("rel_fetch_req", {31'b0, bus.imem_req}, 32'h1);
    chk("rel_fetch_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    #2;
    chk("rel_valid", {31'b0, iv}, 32'h1);
    chk("rel_iaddr", ia, 32'h0);
    chk("rel_word", iw, Key);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
